// File: rtl/ecc_decode_ctrl.sv
// Sequencing controller for the Hamming(16,11) SECDED decode path: collects a
// codeword as two bytes, classifies/corrects it and keeps saturating error counts.
module ecc_decode_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [10:0]      out_data,
    output logic [1:0]       out_status,
    output logic [3:0]       out_syndrome,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_dbl,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_LSW = 3'd0,
        S_MSW = 3'd1,
        S_SYN = 3'd2,
        S_FIX = 3'd3,
        S_OUT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t       state_r;
    logic [15:0]  cw_r;
    logic [3:0]   syn_r;
    logic         par_r;
    logic [15:0]  flip_s;
    logic [1:0]   status_s;
    logic [10:0]  data_s;
    logic         corr_inc_s;
    logic         dbl_inc_s;

    function automatic logic [3:0] calc_syndrome(input logic [15:0] cw);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (cw[i]) begin
                s = s ^ i[3:0];
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

    function automatic logic calc_parity(input logic [15:0] cw);
        return ^cw;
    endfunction

    function automatic logic [10:0] extract_data(input logic [15:0] cw);
        return {cw[15:9], cw[7:5], cw[3]};
    endfunction

    // Classification: odd overall parity means a single flip at position s (s=0 is p0).
    always_comb begin
        flip_s   = 16'd0;
        status_s = 2'b00;
        if (par_r) begin
            flip_s   = 16'd1 << syn_r;
            status_s = 2'b01;
        end else if (syn_r != 4'd0) begin
            status_s = 2'b10;
        end else begin
            status_s = 2'b00;
        end
        data_s     = extract_data(cw_r ^ flip_s);
        corr_inc_s = (state_r == S_FIX) && (status_s == 2'b01);
        dbl_inc_s  = (state_r == S_FIX) && (status_s == 2'b10);
    end

    // Message sequencing FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_LSW;
            cw_r         <= 16'd0;
            syn_r        <= 4'd0;
            par_r        <= 1'b0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_data     <= 11'd0;
            out_status   <= 2'b00;
            out_syndrome <= 4'd0;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                S_LSW: begin
                    if (in_valid) begin
                        cw_r[7:0] <= in_byte;
                        state_r   <= S_MSW;
                        busy      <= 1'b1;
                    end
                end
                S_MSW: begin
                    if (in_valid) begin
                        cw_r[15:8] <= in_byte;
                        state_r    <= S_SYN;
                        in_ready   <= 1'b0;
                    end
                end
                S_SYN: begin
                    syn_r   <= calc_syndrome(cw_r);
                    par_r   <= calc_parity(cw_r);
                    state_r <= S_FIX;
                end
                S_FIX: begin
                    out_data     <= data_s;
                    out_status   <= status_s;
                    out_syndrome <= syn_r;
                    out_valid    <= 1'b1;
                    state_r      <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= S_LSW;
                    end
                end
                default: begin
                    state_r   <= S_LSW;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            cnt_corr <= {CNT_W{1'b0}};
            cnt_dbl  <= {CNT_W{1'b0}};
        end else begin
            if (corr_inc_s && (cnt_corr != CNT_MAX)) begin
                cnt_corr <= cnt_corr + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (dbl_inc_s && (cnt_dbl != CNT_MAX)) begin
                cnt_dbl <= cnt_dbl + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_ecc_decode_ctrl.sv
// Directed self-checking bench for ecc_decode_ctrl (counters built 2 bits wide
// so saturation is reachable in a few messages).
module tb_ecc_decode_ctrl;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_byte;
    logic             out_valid;
    logic             out_ready;
    logic [10:0]      out_data;
    logic [1:0]       out_status;
    logic [3:0]       out_syndrome;
    logic             cnt_clear;
    logic [CNT_W-1:0] cnt_corr;
    logic [CNT_W-1:0] cnt_dbl;
    logic             busy;

    int checks_cnt = 0;
    int errors_cnt = 0;

    ecc_decode_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_byte      (in_byte),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_status   (out_status),
        .out_syndrome (out_syndrome),
        .cnt_clear    (cnt_clear),
        .cnt_corr     (cnt_corr),
        .cnt_dbl      (cnt_dbl),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_byte  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [10:0] d, input logic [1:0] st,
                        input logic [3:0] sy);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_status"}, out_status, st);
        check({tag, "_syn"}, out_syndrome, sy);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"}, out_valid, 0);
        check({tag, "_idle"}, {busy, in_ready}, 2'b01);
    endtask

    initial begin
        logic [10:0] hold_data;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
        cnt_clear = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_outs", {out_valid, out_data, out_status, out_syndrome}, 18'd0);
        check("rst_cnts", {cnt_corr, cnt_dbl}, 4'd0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);

        // Clean codeword with exact latency check.
        send_byte(8'h0F);
        send_byte(8'h00);
        check("lat_k", out_valid, 0);
        check("busy_k", busy, 1);
        tick();
        check("lat_k1", out_valid, 0);
        tick();
        check("lat_k2", out_valid, 1);
        recv("clean", 11'h001, 2'b00, 4'h0);
        check("clean_cnts", {cnt_corr, cnt_dbl}, 4'b0000);

        // Single data-bit error at cw[15].
        send_byte(8'h0F);
        send_byte(8'h80);
        recv("single", 11'h001, 2'b01, 4'hF);
        check("single_cnt", cnt_corr, 1);

        // Double error.
        send_byte(8'h28);
        send_byte(8'h00);
        recv("double", 11'h003, 2'b10, 4'h6);
        check("double_cnt", cnt_dbl, 1);

        // p0-only error.
        send_byte(8'h01);
        send_byte(8'h00);
        recv("p0err", 11'h000, 2'b01, 4'h0);
        check("p0err_cnt", cnt_corr, 2);

        // Backpressure with in_valid held high.
        send_byte(8'h0F);
        send_byte(8'h80);
        tick();
        tick();
        hold_data = out_data;
        in_valid = 1'b1;
        in_byte  = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_hold", {out_data, out_status, out_syndrome}, {hold_data, 2'b01, 4'hF});
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        recv("bp_msg", 11'h001, 2'b01, 4'hF);
        check("bp_sat", cnt_corr, 3);
        send_byte(8'h0F);
        send_byte(8'h00);
        recv("bp_next", 11'h001, 2'b00, 4'h0);

        // Saturation from a cleared counter.
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        check("clr_cnts", {cnt_corr, cnt_dbl}, 4'd0);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h0F);
            send_byte(8'h80);
            recv("sat_msg", 11'h001, 2'b01, 4'hF);
            check("sat_cnt", cnt_corr, (i < 3) ? i + 1 : 3);
        end

        // Clear coinciding with a double-error increment.
        send_byte(8'h28);
        send_byte(8'h00);
        tick();
        cnt_clear = 1'b1;
        check("clr_pre_valid", out_valid, 0);
        tick();
        cnt_clear = 1'b0;
        check("clr_valid", out_valid, 1);
        check("clr_dbl", cnt_dbl, 0);
        check("clr_corr", cnt_corr, 0);
        recv("clr_msg", 11'h003, 2'b10, 4'h6);

        // Reset in the middle of a message.
        send_byte(8'h08);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_state", {busy, in_ready, out_valid}, 3'b010);
        check("mid_rst_outs", {out_data, out_status, out_syndrome}, 17'd0);
        send_byte(8'h0F);
        send_byte(8'h00);
        recv("mid_msg", 11'h001, 2'b00, 4'h0);
        check("mid_cnts", {cnt_corr, cnt_dbl}, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/ecc_decode_ctrl.md
Name: ecc_decode_ctrl

Overview:
- Sequencing controller for the Hamming(16,11) SECDED decode path.
- Accepts a 16-bit codeword as two byte transfers (LSW first, then MSW), then computes the 4-bit syndrome and the overall parity.
- Uses them to correct a single-bit error or flag a double error, and returns the 11 data bits plus a status code.
- Keeps saturating counts of corrected and uncorrectable messages for the program-level error report.

Parameters:
- CNT_W, 8, width of the cnt_corr and cnt_dbl statistic counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_byte holds a valid codeword byte
- in_ready  out  1  controller can accept a byte this cycle
- in_byte  in  8  codeword byte; first transfer = cw[7:0], second transfer = cw[15:8]
- out_valid  out  1  out_data/out_status/out_syndrome are valid
- out_ready  in  1  consumer accepts the result
- out_data  out  11  decoded (corrected where possible) data bits
- out_status  out  2  00 clean, 01 single error corrected, 10 double error; 11 never driven
- out_syndrome  out  4  raw syndrome of the received codeword
- cnt_clear  in  1  synchronous clear of both counters
- cnt_corr  out  CNT_W  number of status-01 results, saturating
- cnt_dbl  out  CNT_W  number of status-10 results, saturating
- busy  out  1  high in any state other than S_LSW

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high, named reset.
- Codeword layout:
  - cw[0] = p0, the overall parity.
  - cw[1], cw[2], cw[4], cw[8] = p1, p2, p4, p8.
  - Data bits in ascending position: d0=cw[3], d1=cw[5], d2=cw[6], d3=cw[7], d4..d10=cw[9]..cw[15].
- Syndrome and parity:
  - s = XOR of indices i (1..15) where cw[i]=1.
  - P = XOR of all 16 bits.
- Classification:
  - s=0, P=0 -> status 00, data unchanged.
  - P=1 -> invert cw[s] (s=0 inverts p0 only), status 01.
  - s!=0, P=0 -> status 10, data extracted uncorrected.
- Handshake: a transfer occurs on a rising edge with valid&&ready high. in_ready and out_valid are state-decoded; there is no combinational path from in_valid or out_ready.
- FSM states:
  - S_LSW: in_ready=1. On transfer, latch cw[7:0] and go to S_MSW.
  - S_MSW: in_ready=1. On transfer, latch cw[15:8] and go to S_SYN.
  - S_SYN: register s and P; go to S_FIX.
  - S_FIX: register corrected data, status and syndrome; update counters; go to S_OUT.
  - S_OUT: out_valid=1. Outputs held stable while out_ready=0. On transfer, go to S_LSW.
- Latency: MSW accepted at edge k -> out_valid high after edge k+2.
- Throughput: one codeword per 5 cycles minimum.
- in_valid during S_SYN/S_FIX/S_OUT is ignored (in_ready=0); the byte is not consumed.
- Counters:
  - Increment once per message in S_FIX, according to the status.
  - Saturate at all-ones.
  - cnt_clear has priority over a same-cycle increment.
  - cnt_clear does not affect the FSM.
- Reset (from any state, including mid-message):
  - State = S_LSW and any partial codeword is discarded.
  - out_valid=0, out_data=0, out_status=00, out_syndrome=0, cnt_corr=0, cnt_dbl=0, busy=0.
  - in_ready=1 from the first cycle after reset deasserts.
- out_valid only falls on an out_valid&&out_ready edge or on reset.

Test Plan:
- Clean codeword: LSW 0x0F, MSW 0x00 -> out_data 0x001, status 00, syndrome 0x0, counters unchanged; out_valid exactly 2 cycles after the MSW edge.
- Single data error: LSW 0x0F, MSW 0x80 (cw[15] flipped) -> out_data 0x001, status 01, syndrome 0xF, cnt_corr=1.
- Double error and p0-only error:
  - LSW 0x28, MSW 0x00 -> out_data 0x003, status 10, syndrome 0x6, cnt_dbl=1.
  - LSW 0x01, MSW 0x00 -> out_data 0x000, status 01, syndrome 0x0.
- Backpressure:
  - Hold out_ready=0 for 4 cycles with in_valid=1 -> outputs stable, in_ready=0, no byte consumed; the next message decodes correctly after out_ready.
  - Counter saturation with CNT_W=2: 5 single-error messages -> cnt_corr sticks at 3.
  - cnt_clear in the same cycle as an increment -> counter reads 0.
- Reset mid-message: accept LSW 0x08, assert reset one cycle, then send LSW 0x0F, MSW 0x00 -> out_data 0x001, status 00 (the stale byte is discarded), counters 0.
